// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy-bird field controllers.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } sched_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Feedback taps on bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pipe_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; shifts left, feedback enters bit 0.
// Runs in every non-reset cycle so later consumers see an independent stream.
module lfsr8
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    // Seed on reset, otherwise advance one position every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Pacing and pattern controller for the scrolling pipe field.
// Produces the one-cycle shift enable for the column cells and the pattern
// injected into the rightmost column (solid pipe with a random gap, then blanks).
//
// state  | meaning
// IDLE   | waiting for start; field blank, no steps
// RUN    | divider counting, steps issued every TICK_DIV clocks
// FROZEN | game lost; everything holds until reset
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int GAP_H      = 3,
    parameter int PIPE_WIDTH = 2,
    parameter int PIPE_SPACE = 4,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    lose,
    output logic                    step,
    output logic [ROWS-1:0]         col_out,
    output logic [$clog2(ROWS)-1:0] gap_row,
    output logic                    running,
    output logic [7:0]              pipes_spawned
);

    localparam int RW     = $clog2(ROWS);
    localparam int PERIOD = PIPE_WIDTH + PIPE_SPACE;
    localparam int PW     = $clog2(PERIOD);
    localparam int DW     = $clog2(TICK_DIV);

    localparam logic [DW-1:0]   DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [ROWS-1:0] GAP_MASK   = {ROWS{1'b1}} >> (ROWS - GAP_H);

    sched_state_t    state;
    logic [DW-1:0]   div;
    logic [PW-1:0]   phase;
    logic [7:0]      lfsr_q;
    logic [RW-1:0]   gap_next;
    logic            unused_lfsr_bits;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Upper LFSR bits are left for other game randomness.
    assign unused_lfsr_bits = ^(lfsr_q >> RW);

    // Fold LFSR indices past the highest legal gap start back into range.
    always_comb begin
        gap_next = lfsr_q[RW-1:0];
        if (int'(lfsr_q[RW-1:0]) > ROWS - GAP_H) begin
            gap_next = RW'(int'(lfsr_q[RW-1:0]) - (ROWS - GAP_H + 1));
        end
    end

    // lose suppresses the step combinationally so a terminal-count cycle never shifts.
    assign step    = (state == RUN) && (div == DIV_LAST) && !lose;
    assign running = (state == RUN);

    // Pipe columns are lit except for the gap; spacing columns and IDLE are blank.
    always_comb begin
        col_out = '0;
        if (state != IDLE && int'(phase) < PIPE_WIDTH) begin
            col_out = ~(GAP_MASK << gap_row);
        end
    end

    // Scheduler FSM with divider, phase counter, gap latch and pipe count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            div           <= '0;
            phase         <= '0;
            gap_row       <= '0;
            pipes_spawned <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        gap_row <= gap_next;
                    end
                end
                RUN: begin
                    if (lose) begin
                        state <= FROZEN;
                    end else if (div == DIV_LAST) begin
                        div <= '0;
                        if (phase == PHASE_LAST) begin
                            phase   <= '0;
                            gap_row <= gap_next;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                        if (phase == '0 && pipes_spawned != 8'hFF) begin
                            pipes_spawned <= pipes_spawned + 8'd1;
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                FROZEN: begin
                    state <= FROZEN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler against a cycle-count reference model.
module tb_pipe_scheduler;

    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, lose, start2, lose2;
    logic       step, running, step2, running2;
    logic [7:0] col_out, col_out2, pipes_spawned, pipes_spawned2;
    logic [2:0] gap_row, gap_row2;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_lfsr;
    int m_cyc, m_steps, m_gap, m_pipes;

    pipe_scheduler #(.ROWS(8), .GAP_H(3), .PIPE_WIDTH(2), .PIPE_SPACE(4), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .lose(lose), .step(step),
        .col_out(col_out), .gap_row(gap_row), .running(running),
        .pipes_spawned(pipes_spawned)
    );

    pipe_scheduler #(.ROWS(8), .GAP_H(3), .PIPE_WIDTH(2), .PIPE_SPACE(4), .TICK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .lose(lose2), .step(step2),
        .col_out(col_out2), .gap_row(gap_row2), .running(running2),
        .pipes_spawned(pipes_spawned2)
    );

    // Bench copy of the LFSR sequence
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int gap_of(input logic [7:0] l);
        int idx;
        idx = int'(l) % 8;
        if (idx > 5) return idx - 6;
        return idx;
    endfunction

    function automatic logic [7:0] pattern(input int ph, input int gap);
        logic [7:0] v;
        if (ph >= 2) return 8'h00;
        v = 8'hFF;
        for (int r = gap; r < gap + 3; r++) v[r] = 1'b0;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (step !== 1'b0 || col_out !== 8'h00 || running !== 1'b0 || pipes_spawned !== 8'h00) begin
                failures++;
                $display("FAIL idle cyc=%0d got step=%0b col=%h run=%0b pipes=%0d need 0/00/0/0",
                         i, step, col_out, running, pipes_spawned);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (step !== 1'b0 || col_out !== 8'h00 || running !== 1'b0 || gap_row !== 3'd0 ||
            pipes_spawned !== 8'h00) begin
            failures++;
            $display("FAIL %s got step=%0b col=%h run=%0b gap=%0d pipes=%0d need all zero",
                     tag, step, col_out, running, gap_row, pipes_spawned);
        end
    endtask

    task automatic begin_run();
        int g;
        start = 1'b1;
        #1;
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL pre_start_running got=%0b need=0", running);
        end
        g = gap_of(m_lfsr);
        @(negedge clk);
        start   = 1'b0;
        m_cyc   = 0;
        m_steps = 0;
        m_gap   = g;
        m_pipes = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int   ph;
            logic exp_step;
            #1;
            exp_step = ((m_cyc % TD) == TD - 1);
            ph = m_steps % 6;
            checks++;
            if (step !== exp_step) begin
                failures++;
                $display("FAIL run_step cyc=%0d got=%0b need=%0b", m_cyc, step, exp_step);
            end
            checks++;
            if (running !== 1'b1) begin
                failures++;
                $display("FAIL run_running cyc=%0d got=%0b need=1", m_cyc, running);
            end
            checks++;
            if (gap_row !== 3'(m_gap)) begin
                failures++;
                $display("FAIL run_gap cyc=%0d got=%0d need=%0d", m_cyc, gap_row, m_gap);
            end
            checks++;
            if (gap_row > 3'd5) begin
                failures++;
                $display("FAIL gap_range cyc=%0d got=%0d need<=5", m_cyc, gap_row);
            end
            checks++;
            if (col_out !== pattern(ph, m_gap)) begin
                failures++;
                $display("FAIL run_col cyc=%0d phase=%0d got=%h need=%h",
                         m_cyc, ph, col_out, pattern(ph, m_gap));
            end
            checks++;
            if (pipes_spawned !== 8'(m_pipes)) begin
                failures++;
                $display("FAIL run_pipes cyc=%0d got=%0d need=%0d", m_cyc, pipes_spawned, m_pipes);
            end
            if (exp_step) begin
                if (ph == 0 && m_pipes < 255) m_pipes++;
                if (ph == 5) m_gap = gap_of(m_lfsr);
                m_steps++;
            end
            m_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; lose = 1'b0; start2 = 1'b0; lose2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("reset_state");
        @(negedge clk);
        idle_cycles(10);
    endtask

    task automatic test_start();
        do_reset();
        idle_cycles($urandom_range(0, 12));
        begin_run();
        run_cycles(16);
        checks++;
        if (pipes_spawned !== 8'd1) begin
            failures++;
            $display("FAIL start_pipes got=%0d need=1", pipes_spawned);
        end
    endtask

    task automatic test_patterns();
        do_reset();
        idle_cycles($urandom_range(0, 30));
        begin_run();
        run_cycles(60 * TD);
        checks++;
        if (pipes_spawned !== 8'd10) begin
            failures++;
            $display("FAIL patterns_pipes got=%0d need=10", pipes_spawned);
        end
    endtask

    task automatic test_lose();
        logic [7:0] hold_col;
        int         hold_gap, hold_pipes;
        run_cycles((TD - 1 - (m_cyc % TD) + TD) % TD);
        lose = 1'b1;
        #1;
        checks++;
        if (step !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL lose_same_cycle got step=%0b run=%0b need step=0 run=1", step, running);
        end
        hold_col   = pattern(m_steps % 6, m_gap);
        hold_gap   = m_gap;
        hold_pipes = m_pipes;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (running !== 1'b0 || step !== 1'b0 || col_out !== hold_col ||
                gap_row !== 3'(hold_gap) || pipes_spawned !== 8'(hold_pipes)) begin
                failures++;
                $display("FAIL frozen cyc=%0d got run=%0b step=%0b col=%h gap=%0d pipes=%0d need 0/0/%h/%0d/%0d",
                         i, running, step, col_out, gap_row, pipes_spawned,
                         hold_col, hold_gap, hold_pipes);
            end
            if (i == 5)  start = 1'b1;
            if (i == 6)  start = 1'b0;
            if (i == 10) lose  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("reset_from_frozen");
        @(negedge clk);
        idle_cycles($urandom_range(0, 9));
        begin_run();
        run_cycles(TD + 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("reset_mid_run");
        @(negedge clk);
        begin_run();
        run_cycles(3 * TD + 1);
    endtask

    task automatic test_saturate();
        int c, nsteps, p, e;
        c = 0; nsteps = 0; p = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (nsteps < 1600 && c < 4000) begin
            #1;
            checks++;
            if (step2 !== ((c % 2) == 1)) begin
                failures++;
                $display("FAIL sat_step cyc=%0d got=%0b need=%0b", c, step2, (c % 2) == 1);
            end
            if (step2 === 1'b1) begin
                e = (p > 255) ? 255 : p;
                checks++;
                if (pipes_spawned2 !== 8'(e)) begin
                    failures++;
                    $display("FAIL sat_pipes step=%0d got=%0d need=%0d", nsteps, pipes_spawned2, e);
                end
                if (nsteps % 6 == 0) p++;
                nsteps++;
            end
            c++;
            @(negedge clk);
        end
        checks++;
        if (nsteps != 1600) begin
            failures++;
            $display("FAIL sat_timeout got steps=%0d need=1600", nsteps);
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (pipes_spawned2 !== 8'd255) begin
                failures++;
                $display("FAIL sat_hold cyc=%0d got=%0d need=255", i, pipes_spawned2);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_patterns();
        test_lose();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
